// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory
// and queues {pc, instr} pairs towards decode; a redirect flushes and restarts fetch.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        count;

    logic [ADDR_WIDTH-1:0] q_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] q_instr [DEPTH];

    logic push;
    logic pop;

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign out_pc    = q_pc[rd_ptr];
    assign out_instr = q_instr[rd_ptr];

    // A full queue may still accept a word when the head leaves in the same cycle.
    assign pop  = out_valid & out_ready & ~redirect_valid;
    assign push = ~redirect_valid & ((count < CNT_FULL) | pop);

    // Queue storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns 0xA0000000 | address.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'hA000_0000 | imem_addr;

    fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        check({tag, " valid"}, 64'(out_valid), 64'd1);
        check({tag, " pc"},    64'(out_pc),    64'(pc));
        check({tag, " instr"}, 64'(out_instr), 64'(32'hA000_0000 | pc));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check("rst valid", 64'(out_valid), 64'd0);
        check("rst addr",  64'(imem_addr), 64'h0);
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        tick();
        tick();

        // Reset then stream with decode always ready
        do_reset();
        check("c0 addr", 64'(imem_addr), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_head("stream", 32'(i * 4));
        end

        // Backpressure: queue fills in two cycles, then fetch stalls at 8
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("bp addr", 64'(imem_addr), (i == 1) ? 64'h4 : 64'h8);
            expect_head("bp hold", 32'h0);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_head("bp drain", 32'(i * 4));
        end

        // Redirect while full, decode ready
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("rd bubble valid", 64'(out_valid), 64'd0);
        check("rd bubble addr",  64'(imem_addr), 64'h100);
        tick();
        expect_head("rd first", 32'h100);
        tick();
        expect_head("rd second", 32'h104);

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        check("mis valid", 64'(out_valid), 64'd0);
        check("mis addr",  64'(imem_addr), 64'h200);
        tick();
        expect_head("mis first", 32'h200);
        tick();
        expect_head("mis second", 32'h204);

        // PC wrap past the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        check("wrap addr", 64'(imem_addr), 64'hFFFF_FFF8);
        tick();
        expect_head("wrap 0", 32'hFFFF_FFF8);
        tick();
        expect_head("wrap 1", 32'hFFFF_FFFC);
        tick();
        expect_head("wrap 2", 32'h0000_0000);
        tick();
        expect_head("wrap 3", 32'h0000_0004);

        // Reset wins over a simultaneous redirect while the queue is non-empty
        check("pre-rst valid", 64'(out_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        do_reset();
        redirect_valid = 1'b0;
        check("rst c0 addr", 64'(imem_addr), 64'h0);
        tick();
        expect_head("rst restart 0", 32'h0);
        tick();
        expect_head("rst restart 1", 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the core's combinational instruction memory. It owns the program counter, drives the word-aligned fetch address into the memory, and captures each returned word with its PC into a small queue. The queue feeds decode through a valid/ready handshake. A redirect input from execute (branch, jump or trap) flushes the queue and restarts fetch at a new PC.

## Interface
- `ADDR_WIDTH`, 32: PC and fetch-address width.
- `DATA_WIDTH`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.
- `DEPTH`, 2: queue entries. Must be a power of two and at least 2.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_addr`  out  ADDR_WIDTH  fetch address to instruction memory; always equal to `fetch_pc`.
- `imem_rdata`  in  DATA_WIDTH  instruction word returned combinationally for `imem_addr` in the same cycle.
- `redirect_valid`  in  1  flush the queue and restart fetch.
- `redirect_pc`  in  ADDR_WIDTH  new fetch PC; sampled when `redirect_valid` is 1.
- `out_valid`  out  1  queue head holds an instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  DATA_WIDTH  head instruction.
- `out_pc`  out  ADDR_WIDTH  PC of the head instruction.

## Operation
- **State:**
  - `fetch_pc` register.
  - Queue of DEPTH entries, each holding {pc, instr}.
  - Read and write pointers of log2(DEPTH) bits that wrap naturally.
  - `count` of log2(DEPTH)+1 bits.
- **Combinational outputs:**
  - `imem_addr = fetch_pc`.
  - `out_valid = (count != 0)`.
  - `out_instr` and `out_pc` are the entry at the read pointer. They hold a stale value when `out_valid` is 0; decode must not use it.
- **Pop:** `pop = out_valid & out_ready & ~redirect_valid`.
- **Push:** `push = ~redirect_valid & ((count < DEPTH) | pop)`. A push is allowed while the queue is full if the same cycle pops, so throughput is one instruction per cycle under continuous `out_ready`.
- **On push:**
  - Write {`fetch_pc`, `imem_rdata`} at the write pointer.
  - `fetch_pc <= fetch_pc + 4`, wrapping modulo 2^ADDR_WIDTH (for example 32'hFFFF_FFFC -> 32'h0000_0000).
- **No push, no redirect:** `fetch_pc` holds and the memory is re-read next cycle.
- **Count update:** `count <= count + push - pop`.
- **Redirect (`redirect_valid` = 1):**
  - Set `count` and both pointers to 0.
  - `fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}`. Misaligned low bits are silently cleared.
  - No push or pop takes effect that cycle, regardless of `out_ready`.
- **Reset (any cycle, including mid-stream or during a redirect):** reset takes priority over everything.
  - `fetch_pc <= RESET_PC`.
  - `count`, pointers <= 0.
  - Queue contents need no reset.
- **Reset values visible in the cycle after reset:**
  - `out_valid` = 0.
  - `imem_addr` = RESET_PC.
  - `out_pc` and `out_instr` are undefined, but must be gated by `out_valid`.
- `out_ready` while `out_valid` = 0 has no effect.

## Timing
- **Fetch latency:** a word fetched at the edge of cycle N is presented at the head in cycle N+1 if the queue was empty.
- **After reset:**
  - First cycle with `reset` = 0 (C0): `imem_addr` = RESET_PC and a push occurs at the end of C0.
  - C1: `out_valid` = 1, `out_pc` = RESET_PC.
- **Redirect latency:** redirect asserted in cycle R gives:
  - R+1: `out_valid` = 0, `imem_addr` = target.
  - R+2: `out_pc` = target, `out_valid` = 1.
  - This is a 2-cycle bubble.
- **Steady state** with `out_ready` held at 1: `out_pc` advances by 4 every cycle and `out_valid` stays at 1.
- **Backpressure:**
  - With `out_ready` at 0, the queue fills in DEPTH cycles, then `fetch_pc` stalls.
  - The head and all entries hold stable while `out_ready` is 0.
- No combinational path from `out_ready` to `out_valid`. The `out_ready` -> `imem_addr` path also does not exist, because `fetch_pc` is registered.

## Test plan
Bench memory model: `imem_rdata = 32'hA000_0000 | imem_addr`.
- **Reset then stream:** release reset with `out_ready` = 1 -> `out_pc`/`out_instr` = 0/A0000000, 4/A0000004, 8/A0000008 on consecutive cycles starting at C1, with no gaps.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles after reset -> `count` saturates at 2 and `imem_addr` stalls at 8. Then raise `out_ready` -> heads 0, 4, 8, C are delivered with no duplicates or drops.
- **Redirect flush:** with the queue full, pulse `redirect_valid` with `redirect_pc` = 32'h100 and `out_ready` = 1 -> next cycle `out_valid` = 0 and no pop is counted. The cycle after: `out_pc` = 100, `out_instr` = A0000100, then 104.
- **Misaligned redirect:** `redirect_pc` = 32'h203 -> `imem_addr` = 200 and first `out_pc` = 200.
- **PC wrap:** redirect to 32'hFFFF_FFF8 -> outputs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- **Reset mid-stream:** assert `reset` for one cycle while `redirect_valid` = 1 and the queue is non-empty -> next cycle `out_valid` = 0 and `imem_addr` = RESET_PC. The stream then restarts at RESET_PC, not at the redirect target.
